// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - glyph codes, segment code type and capture FSM states
package seven_segment_pkg;

  typedef logic [6:0] seg_code_t;

  // Segment codes in a..g order, a at bit 6
  localparam seg_code_t GLYPH_0 = 7'h7E;
  localparam seg_code_t GLYPH_1 = 7'h30;
  localparam seg_code_t GLYPH_2 = 7'h6D;
  localparam seg_code_t GLYPH_3 = 7'h79;
  localparam seg_code_t GLYPH_4 = 7'h33;
  localparam seg_code_t GLYPH_5 = 7'h5B;
  localparam seg_code_t GLYPH_6 = 7'h5F;
  localparam seg_code_t GLYPH_7 = 7'h70;
  localparam seg_code_t GLYPH_8 = 7'h7F;
  localparam seg_code_t GLYPH_9 = 7'h7B;
  localparam seg_code_t GLYPH_A = 7'h77;
  localparam seg_code_t GLYPH_B = 7'h1F;
  localparam seg_code_t GLYPH_C = 7'h4E;
  localparam seg_code_t GLYPH_D = 7'h3D;
  localparam seg_code_t GLYPH_E = 7'h4F;
  localparam seg_code_t GLYPH_F = 7'h47;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_PUBLISH = 2'd1,
    ST_FLUSH   = 2'd2
  } capture_state_t;

  function automatic seg_code_t glyph_code(input logic [3:0] nibble);
    case (nibble)
      4'h0: return GLYPH_0;
      4'h1: return GLYPH_1;
      4'h2: return GLYPH_2;
      4'h3: return GLYPH_3;
      4'h4: return GLYPH_4;
      4'h5: return GLYPH_5;
      4'h6: return GLYPH_6;
      4'h7: return GLYPH_7;
      4'h8: return GLYPH_8;
      4'h9: return GLYPH_9;
      4'hA: return GLYPH_A;
      4'hB: return GLYPH_B;
      4'hC: return GLYPH_C;
      4'hD: return GLYPH_D;
      4'hE: return GLYPH_E;
      default: return GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/seven_segment_glyph_decode.sv
// rtl/seven_segment_glyph_decode.sv - combinational a..g pattern to hex nibble decoder
module seven_segment_glyph_decode
  import seven_segment_pkg::*;
(
  input  seg_code_t  seg,
  output logic       known,
  output logic [3:0] nibble
);

  // Unrecognised patterns, blank included, decode as nibble 0 with known low
  always_comb begin
    known  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == glyph_code(4'(i))) begin
        known  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - captures a multiplexed seven-segment scan back into number/dots frames
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int w_digit       = 8,
  parameter int stable_cycles = 16,
  parameter int invert_seg    = 0,
  parameter int invert_digit  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           abcdefgh,
  input  logic [w_digit-1:0]   digit,
  output logic [w_digit*4-1:0] number,
  output logic [w_digit-1:0]   dots,
  output logic [w_digit-1:0]   known,
  output logic                 frame_valid,
  output logic                 error
);

  localparam int CNT_W   = $clog2(stable_cycles + 1);
  localparam int TIMEOUT = w_digit * stable_cycles * 64;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(stable_cycles - 1);
  localparam logic [CNT_W-1:0] SAT_CNT    = CNT_W'(stable_cycles);
  localparam logic [TMR_W-1:0] TMR_END    = TMR_W'(TIMEOUT);

  logic [7:0]           seg_s1_q, seg_s2_q, seg_cur, seg_prev_q, seg_prev_d;
  logic [w_digit-1:0]   dig_s1_q, dig_s2_q, dig_cur, dig_prev_q, dig_prev_d;
  logic [CNT_W-1:0]     stab_cnt_q, stab_cnt_d;
  logic [TMR_W-1:0]     frame_timer_q, frame_timer_d;
  capture_state_t       state_q, state_d;
  logic [w_digit-1:0]   seen_mask_q, seen_mask_d;
  logic [w_digit*4-1:0] shadow_num_q, shadow_num_d, number_q, number_d;
  logic [w_digit-1:0]   shadow_dot_q, shadow_dot_d, dots_q, dots_d;
  logic [w_digit-1:0]   shadow_known_q, shadow_known_d, known_q, known_d;
  logic                 frame_valid_q, frame_valid_d, error_q, error_d;
  logic                 accept, timeout, glyph_known;
  logic [3:0]           glyph_nibble;

  // Polarity is normalised after the synchronizer so the flops see raw pins
  assign seg_cur = (invert_seg != 0) ? ~seg_s2_q : seg_s2_q;
  assign dig_cur = (invert_digit != 0) ? ~dig_s2_q : dig_s2_q;

  always_comb begin
    seg_prev_d = seg_cur;
    dig_prev_d = dig_cur;
    if ({seg_cur, dig_cur} != {seg_prev_q, dig_prev_q}) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != SAT_CNT) begin
      stab_cnt_d = stab_cnt_q + CNT_W'(1);
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
  end

  // The counter passes ACCEPT_CNT once per dwell, so a dwell gives one accept
  assign accept  = (stab_cnt_q == ACCEPT_CNT) && $onehot(dig_prev_q);
  assign timeout = (frame_timer_q == TMR_END);

  seven_segment_glyph_decode u_decode (
    .seg    (seg_prev_q[7:1]),
    .known  (glyph_known),
    .nibble (glyph_nibble)
  );

  always_comb begin
    shadow_num_d   = shadow_num_q;
    shadow_dot_d   = shadow_dot_q;
    shadow_known_d = shadow_known_q;
    seen_mask_d    = seen_mask_q;
    number_d       = number_q;
    dots_d         = dots_q;
    known_d        = known_q;
    frame_valid_d  = 1'b0;
    error_d        = 1'b0;
    frame_timer_d  = frame_timer_q + TMR_W'(1);
    state_d        = ST_ACQUIRE;

    if (accept) begin
      for (int i = 0; i < w_digit; i++) begin
        if (dig_prev_q[i]) begin
          shadow_num_d[4*i +: 4] = glyph_nibble;
          shadow_dot_d[i]        = seg_prev_q[0];
          shadow_known_d[i]      = glyph_known;
        end
      end
      seen_mask_d = seen_mask_q | dig_prev_q;
      error_d     = !glyph_known;
    end

    // Outputs are loaded on entry to PUBLISH/FLUSH so the pulse lands one clock after the accept
    case (state_q)
      ST_ACQUIRE: begin
        if (&seen_mask_d) begin
          number_d      = shadow_num_d;
          dots_d        = shadow_dot_d;
          known_d       = shadow_known_d;
          frame_valid_d = 1'b1;
          seen_mask_d   = '0;
          frame_timer_d = '0;
          state_d       = ST_PUBLISH;
        end else if (timeout) begin
          shadow_num_d   = '0;
          shadow_dot_d   = '0;
          shadow_known_d = '0;
          seen_mask_d    = '0;
          error_d        = 1'b1;
          frame_timer_d  = '0;
          state_d        = ST_FLUSH;
        end
      end
      default: state_d = ST_ACQUIRE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q       <= '0;
      seg_s2_q       <= '0;
      dig_s1_q       <= '0;
      dig_s2_q       <= '0;
      seg_prev_q     <= '0;
      dig_prev_q     <= '0;
      stab_cnt_q     <= '0;
      frame_timer_q  <= '0;
      state_q        <= ST_ACQUIRE;
      seen_mask_q    <= '0;
      shadow_num_q   <= '0;
      shadow_dot_q   <= '0;
      shadow_known_q <= '0;
      number_q       <= '0;
      dots_q         <= '0;
      known_q        <= '0;
      frame_valid_q  <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      seg_s1_q       <= abcdefgh;
      seg_s2_q       <= seg_s1_q;
      dig_s1_q       <= digit;
      dig_s2_q       <= dig_s1_q;
      seg_prev_q     <= seg_prev_d;
      dig_prev_q     <= dig_prev_d;
      stab_cnt_q     <= stab_cnt_d;
      frame_timer_q  <= frame_timer_d;
      state_q        <= state_d;
      seen_mask_q    <= seen_mask_d;
      shadow_num_q   <= shadow_num_d;
      shadow_dot_q   <= shadow_dot_d;
      shadow_known_q <= shadow_known_d;
      number_q       <= number_d;
      dots_q         <= dots_d;
      known_q        <= known_d;
      frame_valid_q  <= frame_valid_d;
      error_q        <= error_d;
    end
  end

  assign number      = number_q;
  assign dots        = dots_q;
  assign known       = known_q;
  assign frame_valid = frame_valid_q;
  assign error       = error_q;

endmodule
